// File: rtl/router_link_wrap_if.sv
// Router-to-link bundle: per-port flit channels, per-port credit returns and credit error flags.
// slave = the link wrapper, master = the router/link side that drives it.
interface router_link_wrap_if #(
  parameter int num_ports     = 5,
  parameter int vc_idx_width  = 1,
  parameter int channel_width = 68
);
  logic [num_ports*channel_width-1:0]    rtr_channel_op;
  logic [num_ports*channel_width-1:0]    net_channel_op;
  logic [num_ports*(1+vc_idx_width)-1:0] net_flow_ctrl_op;
  logic [num_ports*(1+vc_idx_width)-1:0] rtr_flow_ctrl_op;
  logic [num_ports-1:0]                  error_op;
  logic                                  error;

  modport slave (
    input  rtr_channel_op,
    input  net_flow_ctrl_op,
    output net_channel_op,
    output rtr_flow_ctrl_op,
    output error_op,
    output error
  );

  modport master (
    output rtr_channel_op,
    output net_flow_ctrl_op,
    input  net_channel_op,
    input  rtr_flow_ctrl_op,
    input  error_op,
    input  error
  );
endinterface

// File: rtl/router_link_wrap.sv
// Delays flits and credits by link_delay cycles each way (0 = wires); no backpressure, credits are the flow control.
// ROUTER_LINK_CREDIT_CHECK_EN adds per-port/VC outstanding-flit counters with sticky overflow/underflow flags.
module router_link_wrap #(
  parameter int num_ports      = 5,
  parameter int num_vcs        = 2,
  parameter int vc_idx_width   = 1,
  parameter int channel_width  = 68,
  parameter int link_delay     = 1,
  parameter int credits_per_vc = 8
) (
  input  logic               clk,
  input  logic               reset,
  router_link_wrap_if.slave  lnk
);
  localparam int ch_w = num_ports * channel_width;
  localparam int fc_w = num_ports * (1 + vc_idx_width);

  if (link_delay < 0 || link_delay > 4 || credits_per_vc < 1 || credits_per_vc > 255 ||
      vc_idx_width != $clog2(num_vcs)) begin : g_bad_params
    $error("router_link_wrap: illegal parameter combination");
  end

  if (link_delay == 0) begin : g_wire
    assign lnk.net_channel_op   = lnk.rtr_channel_op;
    assign lnk.rtr_flow_ctrl_op = lnk.net_flow_ctrl_op;
  end else begin : g_pipe
    logic [ch_w-1:0] ch_pipe_d [link_delay];
    logic [ch_w-1:0] ch_pipe_q [link_delay];
    logic [fc_w-1:0] fc_pipe_d [link_delay];
    logic [fc_w-1:0] fc_pipe_q [link_delay];

    always_comb begin
      ch_pipe_d[0] = lnk.rtr_channel_op;
      fc_pipe_d[0] = lnk.net_flow_ctrl_op;
      for (int i = 1; i < link_delay; i++) begin
        ch_pipe_d[i] = ch_pipe_q[i-1];
        fc_pipe_d[i] = fc_pipe_q[i-1];
      end
    end

    // Reset wipes every stage so nothing launched before reset can surface afterwards.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ch_pipe_q <= '{default: '0};
        fc_pipe_q <= '{default: '0};
      end else begin
        ch_pipe_q <= ch_pipe_d;
        fc_pipe_q <= fc_pipe_d;
      end
    end

    assign lnk.net_channel_op   = ch_pipe_q[link_delay-1];
    assign lnk.rtr_flow_ctrl_op = fc_pipe_q[link_delay-1];
  end

`ifdef ROUTER_LINK_CREDIT_CHECK_EN
  localparam int                cnt_w   = $clog2(credits_per_vc + 1);
  localparam logic [cnt_w-1:0]  cnt_max = cnt_w'(credits_per_vc);

  logic [cnt_w-1:0]     cnt_d [num_ports][num_vcs];
  logic [cnt_w-1:0]     cnt_q [num_ports][num_vcs];
  logic [num_ports-1:0] error_op_d;
  logic [num_ports-1:0] error_op_q;
  logic                 flit_hit;
  logic                 crd_hit;

  // Credits are counted where they reach the router, i.e. after the return-path delay.
  always_comb begin
    cnt_d      = cnt_q;
    error_op_d = error_op_q;
    flit_hit   = 1'b0;
    crd_hit    = 1'b0;
    for (int p = 0; p < num_ports; p++) begin
      for (int v = 0; v < num_vcs; v++) begin
        flit_hit = lnk.rtr_channel_op[p*channel_width] &&
                   (lnk.rtr_channel_op[p*channel_width+1 +: vc_idx_width] == vc_idx_width'(v));
        crd_hit  = lnk.rtr_flow_ctrl_op[p*(1+vc_idx_width)] &&
                   (lnk.rtr_flow_ctrl_op[p*(1+vc_idx_width)+1 +: vc_idx_width] == vc_idx_width'(v));
        if (flit_hit && !crd_hit) begin
          if (cnt_q[p][v] == cnt_max) error_op_d[p] = 1'b1;
          else                        cnt_d[p][v]   = cnt_q[p][v] + 1'b1;
        end else if (crd_hit && !flit_hit) begin
          if (cnt_q[p][v] == '0) error_op_d[p] = 1'b1;
          else                   cnt_d[p][v]   = cnt_q[p][v] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '{default: '{default: '0}};
      error_op_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      error_op_q <= error_op_d;
    end
  end

  assign lnk.error_op = error_op_q;
  assign lnk.error    = |error_op_q;
`else
  assign lnk.error_op = '0;
  assign lnk.error    = 1'b0;
`endif

endmodule

// File: tb/tb_router_link_wrap.sv
// Bench for router_link_wrap with link_delay=2: scoreboard queue for both delay paths, behavioural credit-counter model.
module tb_router_link_wrap;
  localparam int NP  = 5;
  localparam int NV  = 2;
  localparam int VW  = 1;
  localparam int CW  = 68;
  localparam int LD  = 2;
  localparam int CPV = 8;
  localparam int FW  = 1 + VW;
`ifdef ROUTER_LINK_CREDIT_CHECK_EN
  localparam bit check_en = 1'b1;
`else
  localparam bit check_en = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  router_link_wrap_if #(.num_ports(NP), .vc_idx_width(VW), .channel_width(CW)) lnk ();

  router_link_wrap #(
    .num_ports(NP), .num_vcs(NV), .vc_idx_width(VW), .channel_width(CW),
    .link_delay(LD), .credits_per_vc(CPV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .lnk  (lnk)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [NP*CW-1:0] exp_ch_q [$];
  logic [NP*FW-1:0] exp_fc_q [$];
  logic [NP*CW-1:0] exp_ch;
  logic [NP*FW-1:0] exp_fc;
  logic [NP-1:0]    exp_err;
  logic [NP-1:0]    mdl_err;
  int               mcnt [NP][NV];

  function automatic logic [NP*CW-1:0] flit(input int port, input int vc);
    logic [NP*CW-1:0] r;
    logic [CW-1:0]    pl;
    r = '0;
    pl = CW'({$urandom, $urandom, $urandom});
    pl[0] = 1'b1;
    pl[VW:1] = VW'(vc);
    r[port*CW +: CW] = pl;
    return r;
  endfunction

  function automatic logic [NP*FW-1:0] credit(input int port, input int vc);
    logic [NP*FW-1:0] r;
    r = '0;
    r[port*FW +: FW] = {VW'(vc), 1'b1};
    return r;
  endfunction

  // Pipeline contents after reset are zeros.
  task automatic model_reset();
    exp_ch_q.delete();
    exp_fc_q.delete();
    for (int i = 0; i < LD; i++) begin
      exp_ch_q.push_back('0);
      exp_fc_q.push_back('0);
    end
    for (int p = 0; p < NP; p++)
      for (int v = 0; v < NV; v++) mcnt[p][v] = 0;
    mdl_err = '0;
    exp_err = '0;
  endtask

  // Drive one cycle of stimulus, then at the negedge pop what the outputs should show now.
  task automatic tick(input logic [NP*CW-1:0] ch, input logic [NP*FW-1:0] fc);
    bit f, c;
    @(posedge clk);
    #1;
    lnk.rtr_channel_op   = ch;
    lnk.net_flow_ctrl_op = fc;
    exp_ch_q.push_back(ch);
    exp_fc_q.push_back(fc);
    @(negedge clk);
    exp_ch  = exp_ch_q.pop_front();
    exp_fc  = exp_fc_q.pop_front();
    exp_err = mdl_err;
    if (check_en) begin
      for (int p = 0; p < NP; p++) begin
        for (int v = 0; v < NV; v++) begin
          f = ch[p*CW] && (ch[p*CW+1 +: VW] == VW'(v));
          c = exp_fc[p*FW] && (exp_fc[p*FW+1 +: VW] == VW'(v));
          if (f && !c) begin
            if (mcnt[p][v] == CPV) mdl_err[p] = 1'b1;
            else                   mcnt[p][v]++;
          end else if (c && !f) begin
            if (mcnt[p][v] == 0) mdl_err[p] = 1'b1;
            else                 mcnt[p][v]--;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    lnk.rtr_channel_op   = '0;
    lnk.net_flow_ctrl_op = '0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    lnk.rtr_channel_op   = '0;
    lnk.net_flow_ctrl_op = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (lnk.net_channel_op !== '0) $display("FAIL rst_net_ch: got %h want 0", lnk.net_channel_op); else n_pass++;
    n_checks++; if (lnk.rtr_flow_ctrl_op !== '0) $display("FAIL rst_rtr_fc: got %h want 0", lnk.rtr_flow_ctrl_op); else n_pass++;
    n_checks++; if (lnk.error_op !== '0) $display("FAIL rst_error_op: got %b want 0", lnk.error_op); else n_pass++;
    n_checks++; if (lnk.error !== 1'b0) $display("FAIL rst_error: got %b want 0", lnk.error); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (lnk.net_channel_op !== '0) $display("FAIL post_rst_net_ch: got %h want 0", lnk.net_channel_op); else n_pass++;
    n_checks++; if (lnk.rtr_flow_ctrl_op !== '0) $display("FAIL post_rst_rtr_fc: got %h want 0", lnk.rtr_flow_ctrl_op); else n_pass++;
    n_checks++; if (lnk.error !== 1'b0) $display("FAIL post_rst_error: got %b want 0", lnk.error); else n_pass++;
  endtask

  task automatic test_delay();
    logic [NP*CW-1:0] ch3, f4, stim, mask3;
    logic [NP*FW-1:0] c4, fcs;
    ch3 = flit(3, 1);
    f4  = flit(4, 1);
    c4  = credit(4, 1);
    mask3 = '0;
    mask3[3*CW +: CW] = '1;
    for (int c = 7; c <= 16; c++) begin
      stim = (c == 7) ? f4 : (c == 10) ? ch3 : '0;
      fcs  = (c == 13) ? c4 : '0;
      tick(stim, fcs);
      n_checks++; if (lnk.net_channel_op !== exp_ch) $display("FAIL delay_ch c%0d: got %h want %h", c, lnk.net_channel_op, exp_ch); else n_pass++;
      n_checks++; if (lnk.rtr_flow_ctrl_op !== exp_fc) $display("FAIL delay_fc c%0d: got %h want %h", c, lnk.rtr_flow_ctrl_op, exp_fc); else n_pass++;
      if (c == 11) begin
        n_checks++; if (lnk.net_channel_op[3*CW +: CW] !== '0) $display("FAIL delay_early: port3 got %h want 0", lnk.net_channel_op[3*CW +: CW]); else n_pass++;
      end
      if (c == 12) begin
        n_checks++; if (lnk.net_channel_op[3*CW +: CW] !== ch3[3*CW +: CW]) $display("FAIL delay_port3: got %h want %h", lnk.net_channel_op[3*CW +: CW], ch3[3*CW +: CW]); else n_pass++;
        n_checks++; if ((lnk.net_channel_op & ~mask3) !== '0) $display("FAIL delay_others: got %h want 0", lnk.net_channel_op & ~mask3); else n_pass++;
      end
      if (c == 15) begin
        n_checks++; if (lnk.rtr_flow_ctrl_op !== c4) $display("FAIL delay_credit: got %h want %h", lnk.rtr_flow_ctrl_op, c4); else n_pass++;
      end
    end
    n_checks++; if (lnk.error_op !== '0) $display("FAIL delay_no_err: got %b want 0", lnk.error_op); else n_pass++;
  endtask

  task automatic test_simul();
    for (int i = 1; i <= 9; i++) begin
      tick(flit(2, 1), (i == 7) ? credit(2, 1) : '0);
      n_checks++; if (lnk.net_channel_op !== exp_ch) $display("FAIL simul_ch i%0d: got %h want %h", i, lnk.net_channel_op, exp_ch); else n_pass++;
      n_checks++; if (lnk.error_op !== exp_err) $display("FAIL simul_err i%0d: got %b want %b", i, lnk.error_op, exp_err); else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      tick('0, '0);
      n_checks++; if (lnk.error_op !== '0) $display("FAIL simul_error_op: got %b want 0", lnk.error_op); else n_pass++;
      n_checks++; if (lnk.error !== 1'b0) $display("FAIL simul_error: got %b want 0", lnk.error); else n_pass++;
    end
`ifdef ROUTER_LINK_CREDIT_CHECK_EN
    n_checks++; if (dut.cnt_q[2][1] !== 4'd8) $display("FAIL simul_cnt: got %0d want 8", dut.cnt_q[2][1]); else n_pass++;
`endif
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 4; i++) begin
      tick('0, (i == 0) ? credit(1, 0) : '0);
      n_checks++; if (lnk.rtr_flow_ctrl_op !== exp_fc) $display("FAIL under_fc i%0d: got %h want %h", i, lnk.rtr_flow_ctrl_op, exp_fc); else n_pass++;
      if (i == 2) begin
        n_checks++; if (lnk.error_op !== '0) $display("FAIL under_early: got %b want 0", lnk.error_op); else n_pass++;
      end
      if (i == 3) begin
        n_checks++; if (lnk.error_op !== (check_en ? 5'b00010 : 5'b00000)) $display("FAIL under_err: got %b want %b", lnk.error_op, check_en ? 5'b00010 : 5'b00000); else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) begin
      tick((i <= 9) ? flit(0, 0) : '0, '0);
      n_checks++; if (lnk.net_channel_op !== exp_ch) $display("FAIL over_ch i%0d: got %h want %h", i, lnk.net_channel_op, exp_ch); else n_pass++;
      if (i == 9) begin
        n_checks++; if (lnk.error_op[0] !== 1'b0) $display("FAIL over_early: got %b want 0", lnk.error_op[0]); else n_pass++;
      end
      if (i == 10) begin
        n_checks++; if (lnk.error_op[0] !== check_en) $display("FAIL over_err0: got %b want %b", lnk.error_op[0], check_en); else n_pass++;
        n_checks++; if (lnk.error !== check_en) $display("FAIL over_error: got %b want %b", lnk.error, check_en); else n_pass++;
        n_checks++; if (lnk.error_op[1] !== check_en) $display("FAIL over_sticky1: got %b want %b", lnk.error_op[1], check_en); else n_pass++;
      end
    end
`ifdef ROUTER_LINK_CREDIT_CHECK_EN
    n_checks++; if (dut.cnt_q[0][0] !== 4'd8) $display("FAIL over_cnt: got %0d want 8", dut.cnt_q[0][0]); else n_pass++;
`endif
  endtask

  task automatic test_reset_inflight();
    logic [NP*CW-1:0] f1, f2;
    f1 = flit(1, 0);
    f2 = flit(1, 1);
    tick(f1, '0);
    tick(f2, credit(3, 0));
    @(posedge clk);
    #1;
    lnk.rtr_channel_op   = '0;
    lnk.net_flow_ctrl_op = '0;
    n_checks++; if (lnk.net_channel_op !== f1) $display("FAIL inflight_pre: got %h want %h", lnk.net_channel_op, f1); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (lnk.net_channel_op !== '0) $display("FAIL async_rst_ch: got %h want 0", lnk.net_channel_op); else n_pass++;
    n_checks++; if (lnk.rtr_flow_ctrl_op !== '0) $display("FAIL async_rst_fc: got %h want 0", lnk.rtr_flow_ctrl_op); else n_pass++;
    n_checks++; if (lnk.error_op !== '0) $display("FAIL async_rst_err: got %b want 0", lnk.error_op); else n_pass++;
    n_checks++; if (lnk.error !== 1'b0) $display("FAIL async_rst_error: got %b want 0", lnk.error); else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick('0, '0);
      n_checks++; if (lnk.net_channel_op !== '0) $display("FAIL inflight_ghost_ch i%0d: got %h want 0", i, lnk.net_channel_op); else n_pass++;
      n_checks++; if (lnk.rtr_flow_ctrl_op !== '0) $display("FAIL inflight_ghost_fc i%0d: got %h want 0", i, lnk.rtr_flow_ctrl_op); else n_pass++;
      n_checks++; if (lnk.error_op !== '0) $display("FAIL inflight_err i%0d: got %b want 0", i, lnk.error_op); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [NP*CW-1:0] ch;
    logic [NP*FW-1:0] fc;
    int pf, pc;
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      pf = (ph == 1) ? 1 : 2;
      pc = (ph == 0) ? 1 : 2;
      for (int n = 0; n < 80; n++) begin
        ch = '0;
        fc = '0;
        for (int p = 0; p < NP; p++) begin
          if ($urandom_range(3) < pf) ch |= flit(p, $urandom_range(NV-1));
          if ($urandom_range(3) < pc) fc |= credit(p, $urandom_range(NV-1));
        end
        tick(ch, fc);
        n_checks++; if (lnk.net_channel_op !== exp_ch) $display("FAIL b2b_ch p%0d n%0d: got %h want %h", ph, n, lnk.net_channel_op, exp_ch); else n_pass++;
        n_checks++; if (lnk.rtr_flow_ctrl_op !== exp_fc) $display("FAIL b2b_fc p%0d n%0d: got %h want %h", ph, n, lnk.rtr_flow_ctrl_op, exp_fc); else n_pass++;
        n_checks++; if (lnk.error_op !== exp_err) $display("FAIL b2b_err p%0d n%0d: got %b want %b", ph, n, lnk.error_op, exp_err); else n_pass++;
        n_checks++; if (lnk.error !== (|exp_err)) $display("FAIL b2b_error p%0d n%0d: got %b want %b", ph, n, lnk.error, |exp_err); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_delay();
    test_simul();
    test_underflow();
    test_overflow();
    test_reset_inflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
